// File: rtl/gemm_tiled_engine.sv
`default_nettype none
// ============================================================================
// Module   : gemm_tiled_engine
// Summary  : Tiled output-stationary GeMM engine (C = A*B) over tile SRAMs.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_tiled_engine #(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8,
  parameter int M             = 4,
  parameter int K             = 4,
  parameter int N             = 4,
  parameter int ReadLatency   = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [SizeAddrWidth-1:0]          M_size_i,
  input  logic [SizeAddrWidth-1:0]          K_size_i,
  input  logic [SizeAddrWidth-1:0]          N_size_i,
  input  logic                              signed_i,
  input  logic                              b_trans_i,
  input  logic                              stall_i,
  output logic [AddrWidth-1:0]              sram_a_addr_o,
  output logic [AddrWidth-1:0]              sram_b_addr_o,
  output logic                              sram_a_re_o,
  output logic                              sram_b_re_o,
  input  logic [InDataWidth*M*K-1:0]        sram_a_rdata_i,
  input  logic [InDataWidth*K*N-1:0]        sram_b_rdata_i,
  output logic [AddrWidth-1:0]              sram_c_addr_o,
  output logic [OutDataWidth*M*N-1:0]       sram_c_wdata_o,
  output logic                              sram_c_we_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [SizeAddrWidth-1:0] c_one = SizeAddrWidth'(1);

  state_e r_state, w_state_nxt;

  logic [SizeAddrWidth-1:0] r_mt_tiles, r_kt_tiles, r_nt_tiles;
  logic [SizeAddrWidth-1:0] r_mt, r_kt, r_nt;
  logic                     r_signed, r_b_trans, r_err, r_we;
  logic [AddrWidth-1:0]     r_c_addr;
  logic                     w_legal, w_accept, w_reject, w_issue;
  logic                     w_kt_last, w_nt_last, w_mt_last, w_kt_first;
  logic [AddrWidth-1:0]     w_c_addr;

  logic [ReadLatency-1:0]   r_pv, r_pfirst, r_plast;
  logic [AddrWidth-1:0]     r_paddr [ReadLatency];
  logic                     w_beat, w_beat_first, w_beat_last;

  logic [OutDataWidth-1:0]  r_acc     [M][N];
  logic [OutDataWidth-1:0]  w_acc_nxt [M][N];
  logic [OutDataWidth-1:0]  w_sum;

  function automatic logic [OutDataWidth-1:0] ext(input logic [InDataWidth-1:0] x,
                                                  input logic sgn);
    return {{(OutDataWidth-InDataWidth){sgn & x[InDataWidth-1]}}, x};
  endfunction

  // Sizes must be non-zero whole multiples of the tile shape.
  assign w_legal = (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0) &&
                   ((M_size_i % SizeAddrWidth'(M)) == '0) &&
                   ((K_size_i % SizeAddrWidth'(K)) == '0) &&
                   ((N_size_i % SizeAddrWidth'(N)) == '0);

  assign w_kt_first = (r_kt == '0);
  assign w_kt_last  = (r_kt == r_kt_tiles - c_one);
  assign w_nt_last  = (r_nt == r_nt_tiles - c_one);
  assign w_mt_last  = (r_mt == r_mt_tiles - c_one);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!stall_i) begin
          w_issue = 1'b1;
          if (w_kt_last && w_nt_last && w_mt_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (r_pv == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Issue counters walk mt (outer), nt, kt (inner).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mt_tiles <= '0;
      r_kt_tiles <= '0;
      r_nt_tiles <= '0;
      r_signed   <= 1'b0;
      r_b_trans  <= 1'b0;
      r_mt       <= '0;
      r_kt       <= '0;
      r_nt       <= '0;
    end else if (w_accept) begin
      r_mt_tiles <= M_size_i / SizeAddrWidth'(M);
      r_kt_tiles <= K_size_i / SizeAddrWidth'(K);
      r_nt_tiles <= N_size_i / SizeAddrWidth'(N);
      r_signed   <= signed_i;
      r_b_trans  <= b_trans_i;
      r_mt       <= '0;
      r_kt       <= '0;
      r_nt       <= '0;
    end else if (w_issue) begin
      if (w_kt_last) begin
        r_kt <= '0;
        if (w_nt_last) begin
          r_nt <= '0;
          r_mt <= w_mt_last ? '0 : r_mt + c_one;
        end else begin
          r_nt <= r_nt + c_one;
        end
      end else begin
        r_kt <= r_kt + c_one;
      end
    end
  end

  assign sram_a_addr_o = AddrWidth'(r_mt) * AddrWidth'(r_kt_tiles) + AddrWidth'(r_kt);
  assign sram_b_addr_o = r_b_trans ?
                         AddrWidth'(r_nt) * AddrWidth'(r_kt_tiles) + AddrWidth'(r_kt) :
                         AddrWidth'(r_kt) * AddrWidth'(r_nt_tiles) + AddrWidth'(r_nt);
  assign w_c_addr      = AddrWidth'(r_mt) * AddrWidth'(r_nt_tiles) + AddrWidth'(r_nt);
  assign sram_a_re_o   = w_issue;
  assign sram_b_re_o   = w_issue;

  // Tag pipeline mirrors the SRAM latency so each beat knows its role.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pv     <= '0;
      r_pfirst <= '0;
      r_plast  <= '0;
      for (int i = 0; i < ReadLatency; i++) r_paddr[i] <= '0;
    end else begin
      r_pv[0]     <= w_issue;
      r_pfirst[0] <= w_kt_first;
      r_plast[0]  <= w_kt_last;
      r_paddr[0]  <= w_c_addr;
      for (int i = 1; i < ReadLatency; i++) begin
        r_pv[i]     <= r_pv[i-1];
        r_pfirst[i] <= r_pfirst[i-1];
        r_plast[i]  <= r_plast[i-1];
        r_paddr[i]  <= r_paddr[i-1];
      end
    end
  end

  assign w_beat       = r_pv[ReadLatency-1];
  assign w_beat_first = r_pfirst[ReadLatency-1];
  assign w_beat_last  = r_plast[ReadLatency-1];

  always_comb begin
    w_sum = '0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        w_sum = '0;
        for (int k = 0; k < K; k++) begin
          w_sum = w_sum +
                  ext(sram_a_rdata_i[(m*K+k)*InDataWidth +: InDataWidth], r_signed) *
                  ext(r_b_trans ? sram_b_rdata_i[(n*K+k)*InDataWidth +: InDataWidth]
                                : sram_b_rdata_i[(k*N+n)*InDataWidth +: InDataWidth],
                      r_signed);
        end
        w_acc_nxt[m][n] = w_beat_first ? w_sum : r_acc[m][n] + w_sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++)
          r_acc[m][n] <= '0;
      r_we     <= 1'b0;
      r_c_addr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_beat) begin
        for (int m = 0; m < M; m++)
          for (int n = 0; n < N; n++)
            r_acc[m][n] <= w_acc_nxt[m][n];
      end
      r_we  <= w_beat & w_beat_last;
      r_err <= w_reject;
      if (w_beat && w_beat_last) r_c_addr <= r_paddr[ReadLatency-1];
    end
  end

  always_comb begin
    sram_c_wdata_o = '0;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        sram_c_wdata_o[(m*N+n)*OutDataWidth +: OutDataWidth] = r_acc[m][n];
  end

  assign sram_c_addr_o = r_c_addr;
  assign sram_c_we_o   = r_we;
  assign busy_o        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o        = (r_state == S_DONE);
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gemm_tiled_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_tiled_engine
// Summary  : Randomised self-checking bench, two engines (latency 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_tiled_engine;
  localparam int W = 8, OW = 32, TM = 4, TK = 4, TN = 4;
  localparam int MAXD = 16, MAXC = 256;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, sgn = 1'b0, btr = 1'b0, stall = 1'b0;
  logic [7:0] msz = '0, ksz = '0, nsz = '0;
  logic [127:0] amem [32];
  logic [127:0] bmem [32];
  logic [15:0]  a_addr [2];
  logic [15:0]  b_addr [2];
  logic [15:0]  c_addr [2];
  logic [511:0] wdata  [2];
  logic [1:0]   re_a, re_b, we, busy, done, err;
  logic [7:0]   A_el [MAXD][MAXD];
  logic [7:0]   B_el [MAXD][MAXD];
  bit           exp_iss [MAXC];
  logic [15:0]  exp_a [MAXC];
  logic [15:0]  exp_b [MAXC];
  bit           exp_w  [2][MAXC];
  int           exp_wt [2][MAXC];
  int           n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [127:0] a_rd = '0, b_rd = '0;
    logic [15:0]  ha [LAT];
    logic [15:0]  hb [LAT];
    logic         hv [LAT] = '{default: 1'b0};

    gemm_tiled_engine #(.ReadLatency(LAT)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start),
      .M_size_i(msz), .K_size_i(ksz), .N_size_i(nsz),
      .signed_i(sgn), .b_trans_i(btr), .stall_i(stall),
      .sram_a_addr_o(a_addr[g]), .sram_b_addr_o(b_addr[g]),
      .sram_a_re_o(re_a[g]), .sram_b_re_o(re_b[g]),
      .sram_a_rdata_i(a_rd), .sram_b_rdata_i(b_rd),
      .sram_c_addr_o(c_addr[g]), .sram_c_wdata_o(wdata[g]), .sram_c_we_o(we[g]),
      .busy_o(busy[g]), .done_o(done[g]), .err_o(err[g])
    );

    // SRAM model: a read issued in cycle c returns data throughout cycle c+LAT.
    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
        ha[i] = ha[i-1];
        hb[i] = hb[i-1];
        hv[i] = hv[i-1];
      end
      ha[0] = a_addr[g];
      hb[0] = b_addr[g];
      hv[0] = re_a[g];
      #1;
      a_rd = hv[LAT-1] ? amem[ha[LAT-1][4:0]] : {$urandom, $urandom, $urandom, $urandom};
      b_rd = hv[LAT-1] ? bmem[hb[LAT-1][4:0]] : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [7:0] x, input bit sg);
    return sg ? {{24{x[7]}}, x} : {24'b0, x};
  endfunction

  // Golden C tile from the full matrices, summing over the whole K dimension.
  function automatic logic [511:0] c_tile(input int mt, input int nt, input int ks, input bit sg);
    logic [511:0] t = '0;
    for (int m = 0; m < TM; m++) begin
      for (int n = 0; n < TN; n++) begin
        logic [31:0] s = '0;
        for (int kk = 0; kk < ks; kk++)
          s = s + opnd(A_el[mt*TM+m][kk], sg) * opnd(B_el[kk][nt*TN+n], sg);
        t[(m*TN+n)*OW +: OW] = s;
      end
    end
    return t;
  endfunction

  task automatic fill(input int mode);
    if (mode == 3) return;
    for (int i = 0; i < MAXD; i++)
      for (int j = 0; j < MAXD; j++) begin
        case (mode)
          0:       begin A_el[i][j] = 8'($urandom); B_el[i][j] = 8'($urandom); end
          1:       begin A_el[i][j] = (i == j) ? 8'd1 : 8'd0; B_el[i][j] = 8'(i*4 + j); end
          default: begin A_el[i][j] = 8'hFF; B_el[i][j] = 8'hFF; end
        endcase
      end
  endtask

  task automatic pack(input bit bt, input int Mt, input int Kt, input int Nt);
    for (int i = 0; i < 32; i++) begin amem[i] = '0; bmem[i] = '0; end
    for (int kt = 0; kt < Kt; kt++)
      for (int k = 0; k < TK; k++) begin
        for (int mt = 0; mt < Mt; mt++)
          for (int m = 0; m < TM; m++)
            amem[mt*Kt+kt][(m*TK+k)*W +: W] = A_el[mt*TM+m][kt*TK+k];
        for (int nt = 0; nt < Nt; nt++)
          for (int n = 0; n < TN; n++)
            if (bt) bmem[nt*Kt+kt][(n*TK+k)*W +: W] = B_el[kt*TK+k][nt*TN+n];
            else    bmem[kt*Nt+nt][(k*TN+n)*W +: W] = B_el[kt*TK+k][nt*TN+n];
      end
  endtask

  task automatic run_job(input string nm, input int ms, input int ks, input int ns,
                         input bit sg, input bit bt, input int mode,
                         input int stall_at, input int bstart_at, input int rst_at);
    int  Mt, Kt, Nt, rel, last, lim;
    int  lat [2] = '{1, 3};
    int  dn  [2] = '{-1, -1};
    bit  legal, st;
    logic [1:0] e_re, e_we, e_bz, e_dn, e_er;
    legal = ms > 0 && ks > 0 && ns > 0 && ms % TM == 0 && ks % TK == 0 && ns % TN == 0;
    Mt = ms / TM; Kt = ks / TK; Nt = ns / TN;
    last = 0; lim = 8;
    for (int c = 0; c < MAXC; c++) begin
      exp_iss[c] = 0; exp_w[0][c] = 0; exp_w[1][c] = 0;
    end
    if (legal) begin
      fill(mode);
      pack(bt, Mt, Kt, Nt);
      rel = 1;
      for (int mt = 0; mt < Mt; mt++)
        for (int nt = 0; nt < Nt; nt++)
          for (int kt = 0; kt < Kt; kt++) begin
            while (stall_at > 0 && (rel == stall_at || rel == stall_at + 1)) rel++;
            exp_iss[rel] = 1;
            exp_a[rel]   = 16'(mt*Kt + kt);
            exp_b[rel]   = bt ? 16'(nt*Kt + kt) : 16'(kt*Nt + nt);
            if (kt == Kt - 1)
              for (int g = 0; g < 2; g++) begin
                exp_w[g][rel+lat[g]+1]  = 1;
                exp_wt[g][rel+lat[g]+1] = mt*Nt + nt;
              end
            last = rel;
            rel++;
          end
      for (int g = 0; g < 2; g++) dn[g] = last + lat[g] + 2;
      lim = dn[1] + 3;
    end
    for (rel = 0; rel <= lim; rel++) begin
      @(negedge clk);
      start = (rel == 0) || (rel == bstart_at);
      msz   = (rel == bstart_at) ? 8'd6 : 8'(ms);
      ksz   = 8'(ks);
      nsz   = 8'(ns);
      sgn   = (rel == bstart_at) ? ~sg : sg;
      btr   = bt;
      st    = stall_at > 0 && (rel == stall_at || rel == stall_at + 1);
      stall = st;
      if (rel == rst_at) rst_n = 1'b0;
      #1;
      if (rel == rst_at) begin
        chk($sformatf("%s/rst_ctl", nm), 512'({re_a, re_b, we, busy, done, err}), 512'(0));
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("%s/rst_addr%0d", nm, g), 512'({a_addr[g], b_addr[g], c_addr[g]}), 512'(0));
          chk($sformatf("%s/rst_wdata%0d", nm, g), wdata[g], 512'(0));
        end
        break;
      end
      for (int g = 0; g < 2; g++) begin
        e_re[g] = exp_iss[rel];
        e_we[g] = exp_w[g][rel];
        e_bz[g] = legal && rel >= 1 && rel < dn[g];
        e_dn[g] = (rel == dn[g]);
        e_er[g] = !legal && rel == 1;
      end
      chk($sformatf("%s/ctl@%0d", nm, rel), 512'({re_a, re_b, we, busy, done, err}),
          512'({e_re, e_re, e_we, e_bz, e_dn, e_er}));
      for (int g = 0; g < 2; g++) begin
        if (exp_iss[rel]) begin
          chk($sformatf("%s/a_addr%0d@%0d", nm, g, rel), 512'(a_addr[g]), 512'(exp_a[rel]));
          chk($sformatf("%s/b_addr%0d@%0d", nm, g, rel), 512'(b_addr[g]), 512'(exp_b[rel]));
        end
        if (exp_w[g][rel]) begin
          chk($sformatf("%s/c_addr%0d@%0d", nm, g, rel), 512'(c_addr[g]), 512'(exp_wt[g][rel]));
          chk($sformatf("%s/c_data%0d@%0d", nm, g, rel), wdata[g],
              c_tile(exp_wt[g][rel] / Nt, exp_wt[g][rel] % Nt, ks, sg));
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    rst_n = 1'b1;
    if (rst_at >= 0) begin
      for (int i = 0; i < 10; i++) begin
        #1;
        chk($sformatf("%s/post_rst@%0d", nm, i), 512'({re_a, re_b, we, busy, done, err}), 512'(0));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 512'({re_a, re_b, we, busy, done, err}), 512'(0));
    for (int g = 0; g < 2; g++) begin
      chk("reset_addr", 512'({a_addr[g], b_addr[g], c_addr[g]}), 512'(0));
      chk("reset_wdata", wdata[g], 512'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job("single",  4,  4,  4, 0, 0, 1, -1, -1, -1);
    run_job("s888",    8,  8,  8, 1, 0, 0, -1, -1, -1);
    run_job("ff_sgn",  4,  4,  4, 1, 0, 2, -1, -1, -1);
    run_job("ff_uns",  4,  4,  4, 0, 0, 2, -1, -1, -1);
    run_job("b_norm",  4,  8,  8, 1, 0, 0, -1, -1, -1);
    run_job("b_trans", 4,  8,  8, 1, 1, 3, -1, -1, -1);
    run_job("stall",  12,  8, 16, 0, 0, 0,  3,  5, -1);
    run_job("kt1",     8,  4,  8, 1, 0, 0,  2, -1, -1);
    run_job("bad_m",   6,  4,  4, 0, 0, 0, -1, -1, -1);
    run_job("bad_k",   4,  0,  4, 0, 0, 0, -1, -1, -1);
    run_job("mid_rst", 8,  8,  8, 1, 0, 0, -1, -1,  4);
    run_job("after",   4,  8,  4, 0, 1, 0, -1, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
